// File: rtl/cgra_cfg_pkg.sv
// Shared constants and types for the CGRA configuration/run controller.
package cgra_cfg_pkg;

  localparam int unsigned NUM_TILES_DEF = 4;
  localparam int unsigned CFG_AW_DEF    = 4;

  // Header byte field positions
  localparam int unsigned OP_MSB   = 7;
  localparam int unsigned OP_LSB   = 6;
  localparam int unsigned TILE_MSB = 5;
  localparam int unsigned TILE_LSB = 4;
  localparam int unsigned ADDR_MSB = 3;
  localparam int unsigned ADDR_LSB = 0;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_RUN   = 2'b10,
    OP_STOP  = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_LEN   = 3'd1,
    W_DATA  = 3'd2,
    R_CNT   = 3'd3,
    RUNNING = 3'd4
  } state_t;

endpackage

// File: rtl/cfg_run_timer.sv
// 8-bit loadable down-counter that owns the array run enable and done pulse.
// A load count of zero means run until cleared.
module cfg_run_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] count,
  input  logic       clear,
  output logic       active,
  output logic       expire_pulse,
  output logic       expiring
);

  logic       active_q;
  logic [7:0] cnt_q;
  logic       pulse_q;

  // Last cycle of a finite run: the run drops at the next edge
  assign expiring     = active_q && (cnt_q == 8'd1);
  assign active       = active_q;
  assign expire_pulse = pulse_q;

  // Run enable, remaining-cycle counter and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (clear) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end else if (load) begin
        active_q <= 1'b1;
        cnt_q    <= count;
      end else if (expiring) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
        pulse_q  <= 1'b1;
      end else if (active_q && (cnt_q != 8'd0)) begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

endmodule

// File: rtl/cgra_cfg_ctrl.sv
// Byte-serial command parser: turns WRITE/RUN/STOP commands into per-tile
// configuration writes and array run control.
module cgra_cfg_ctrl
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned NUM_TILES = NUM_TILES_DEF,
  parameter int unsigned CFG_AW    = CFG_AW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic [NUM_TILES-1:0] cfg_wr_en,
  output logic [CFG_AW-1:0]    cfg_addr,
  output logic [7:0]           cfg_data,
  output logic                 run,
  output logic [NUM_TILES-1:0] tile_en,
  output logic                 done,
  output logic                 busy,
  output logic                 err
);

  state_t state_q, state_d;

  logic                 in_ready_q, in_ready_d;
  logic [NUM_TILES-1:0] wr_en_q, wr_en_d;
  logic [CFG_AW-1:0]    cfg_addr_q, cfg_addr_d;
  logic [7:0]           cfg_data_q, cfg_data_d;
  logic [NUM_TILES-1:0] tile_en_q, tile_en_d;
  logic                 err_q, err_d;
  logic [1:0]           tile_q, tile_d;
  logic [CFG_AW-1:0]    addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [NUM_TILES-1:0] mask_q, mask_d;
  logic                 discard_q, discard_d;

  logic    tm_load, tm_clear;
  logic    run_w, done_w, expiring_w;
  logic    xfer;
  opcode_t op;

  assign xfer = in_valid && in_ready_q;
  assign op   = opcode_t'(in_data[OP_MSB:OP_LSB]);

  cfg_run_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .load         (tm_load),
    .count        (in_data),
    .clear        (tm_clear),
    .active       (run_w),
    .expire_pulse (done_w),
    .expiring     (expiring_w)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (op == OP_WRITE)    state_d = W_LEN;
          else if (op == OP_RUN) state_d = R_CNT;
        end
      end
      W_LEN:   if (xfer) state_d = W_DATA;
      W_DATA:  if (xfer && (len_q == 8'd0)) state_d = IDLE;
      R_CNT:   if (xfer) state_d = (in_data == 8'd0) ? IDLE : RUNNING;
      RUNNING: if (expiring_w) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: header decode, length count, address increment
  always_comb begin
    in_ready_d = (state_d != RUNNING);
    wr_en_d    = '0;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    tile_en_d  = expiring_w ? '0 : tile_en_q;
    err_d      = err_q;
    tile_d     = tile_q;
    addr_d     = addr_q;
    len_d      = len_q;
    mask_d     = mask_q;
    discard_d  = discard_q;
    tm_load    = 1'b0;
    tm_clear   = 1'b0;
    if (xfer) begin
      unique case (state_q)
        IDLE: begin
          unique case (op)
            OP_WRITE: begin
              tile_d    = in_data[TILE_MSB:TILE_LSB];
              addr_d    = CFG_AW'(in_data[ADDR_MSB:ADDR_LSB]);
              discard_d = run_w;
              if (run_w) err_d = 1'b1;
            end
            OP_RUN: begin
              mask_d = NUM_TILES'(in_data[ADDR_MSB:ADDR_LSB]);
              if (run_w || (in_data[TILE_MSB:TILE_LSB] != 2'b00)) err_d = 1'b1;
            end
            OP_STOP: begin
              tm_clear  = 1'b1;
              tile_en_d = '0;
              if (in_data[5:0] != 6'd0) err_d = 1'b1;
            end
            default: ;
          endcase
        end
        W_LEN: len_d = in_data;
        W_DATA: begin
          if (!discard_q) begin
            wr_en_d    = NUM_TILES'(1) << tile_q;
            cfg_addr_d = addr_q;
            cfg_data_d = in_data;
          end
          addr_d = addr_q + CFG_AW'(1);
          len_d  = len_q - 8'd1;
        end
        R_CNT: begin
          tm_load   = 1'b1;
          tile_en_d = mask_q;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q <= 1'b1;
      wr_en_q    <= '0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      tile_en_q  <= '0;
      err_q      <= 1'b0;
      tile_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      mask_q     <= '0;
      discard_q  <= 1'b0;
    end else begin
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
      tile_en_q  <= tile_en_d;
      err_q      <= err_d;
      tile_q     <= tile_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      mask_q     <= mask_d;
      discard_q  <= discard_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign cfg_wr_en = wr_en_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign run       = run_w;
  assign tile_en   = tile_en_q;
  assign done      = done_w;
  assign busy      = (state_q != IDLE) || run_w;
  assign err       = err_q;

endmodule

// File: tb/tb_cgra_cfg_ctrl.sv
// Scoreboard bench for cgra_cfg_ctrl: expected config writes and run lengths
// are queued by the stimulus and consumed by a negedge monitor.
module tb_cgra_cfg_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [3:0] cfg_wr_en;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       run;
  logic [3:0] tile_en;
  logic       done;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  cgra_cfg_ctrl #(.NUM_TILES(4), .CFG_AW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cfg_wr_en (cfg_wr_en),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .run       (run),
    .tile_en   (tile_en),
    .done      (done),
    .busy      (busy),
    .err       (err)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] cfg_exp_q[$];
  int          run_exp_q[$];
  int          run_len  = 0;
  int          done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe and done pulse must match the head of its queue
  always @(negedge clk) begin
    if (!reset) begin
      if (cfg_wr_en != 4'b0000) begin
        if (cfg_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cfg_wr: got %b/%0h/%0h expected none", cfg_wr_en, cfg_addr, cfg_data);
        end else begin
          chk("cfg_wr", {16'h0, cfg_wr_en, cfg_addr, cfg_data}, {16'h0, cfg_exp_q.pop_front()});
        end
      end
      if (done) begin
        if (run_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          chk("run_len", run_len, run_exp_q.pop_front());
          chk("ready_at_done", in_ready, 1);
          chk("run_at_done", run, 0);
        end
        done_cnt++;
      end
      if (run) run_len++;
      else     run_len = 0;
    end else begin
      run_len = 0;
    end
  end

  task automatic send(input logic [7:0] b);
    int   n;
    logic ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 300);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for byte %0h", b);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pulses expected %0d", done_cnt, target);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_cfg_wr_en"}, cfg_wr_en, 0);
    chk({tag, "_cfg_addr"}, cfg_addr, 0);
    chk({tag, "_cfg_data"}, cfg_data, 0);
    chk({tag, "_run"}, run, 0);
    chk({tag, "_tile_en"}, tile_en, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    check_reset_vals("rst0");

    // WRITE tile 1 from addr 14, three bytes, wraps 15 -> 0
    cfg_exp_q.push_back({4'b0010, 4'd14, 8'hA1});
    cfg_exp_q.push_back({4'b0010, 4'd15, 8'hA2});
    cfg_exp_q.push_back({4'b0010, 4'd0,  8'hA3});
    send(8'h5E); send(8'h02); send(8'hA1); send(8'hA2); send(8'hA3);
    idle(3);
    chk("wr1_drained", cfg_exp_q.size(), 0);
    chk("wr1_busy", busy, 0);

    // Single-byte WRITE to tile 3 addr 15
    cfg_exp_q.push_back({4'b1000, 4'd15, 8'h99});
    send(8'h7F); send(8'h00); send(8'h99);
    idle(3);
    chk("wr2_drained", cfg_exp_q.size(), 0);

    // Finite RUN, mask 0101, 3 cycles
    run_exp_q.push_back(3);
    send(8'h85); send(8'h03);
    chk("frun_run", run, 1);
    chk("frun_tile_en", tile_en, 4'b0101);
    chk("frun_in_ready", in_ready, 0);
    chk("frun_busy", busy, 1);
    wait_done(1);
    idle(2);
    chk("frun_done_low", done, 0);

    // Finite RUN with mask 0, 2 cycles
    run_exp_q.push_back(2);
    send(8'h80); send(8'h02);
    chk("m0_run", run, 1);
    chk("m0_tile_en", tile_en, 0);
    wait_done(2);

    // Indefinite RUN then STOP
    send(8'h8F); send(8'h00);
    chk("irun_run", run, 1);
    chk("irun_tile_en", tile_en, 4'b1111);
    chk("irun_in_ready", in_ready, 1);
    idle(5);
    chk("irun_hold", run, 1);
    send(8'hC0);
    chk("stop_run", run, 0);
    chk("stop_tile_en", tile_en, 0);
    chk("stop_err", err, 0);
    idle(3);
    chk("stop_busy", busy, 0);

    // WRITE during indefinite run is discarded with error
    send(8'h81); send(8'h00);
    chk("wdr_err_before", err, 0);
    send(8'h40);
    chk("wdr_err", err, 1);
    send(8'h00); send(8'h55);
    idle(3);
    chk("wdr_run", run, 1);
    chk("wdr_tile_en", tile_en, 4'b0001);

    // STOP with reserved bits: executes and flags error
    send(8'hC5);
    chk("rsv_run", run, 0);
    chk("rsv_err", err, 1);
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check_reset_vals("rst1");

    // Reset during a long finite run
    send(8'h81); send(8'hC8);
    idle(10);
    chk("lrun_run", run, 1);
    chk("lrun_in_ready", in_ready, 0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("mrst_run", run, 0);
    chk("mrst_done", done, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_busy", busy, 0);
    idle(5);
    chk("mrst_done_later", done, 0);
    chk("mrst_run_later", run, 0);

    chk("cfg_q_empty", cfg_exp_q.size(), 0);
    chk("run_q_empty", run_exp_q.size(), 0);
    chk("done_total", done_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
